// File: rtl/alu_cmd_responder.sv
// rtl/alu_cmd_responder.sv - ALU request/response responder, one op in flight
// Single-cycle ALU ops plus an 8-iteration shift-add multiplier behind a held response channel.
module alu_cmd_responder #(
  parameter int TAG_W      = 4,
  parameter int ENABLE_MUL = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_op,
  input  logic [7:0]       req_a,
  input  logic [7:0]       req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_result,
  output logic [3:0]       rsp_flags,
  output logic             rsp_err,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]       r_state;
  logic             r_alive;
  logic [2:0]       r_iter;
  logic [15:0]      r_mcand;
  logic [15:0]      r_prod;
  logic [7:0]       r_mplier;
  logic [7:0]       r_result;
  logic [3:0]       r_flags;
  logic             r_err;
  logic [TAG_W-1:0] r_tag;
  logic [CNT_W-1:0] r_count;

  logic        w_accept;
  logic        w_is_mul;
  logic        w_illegal;
  logic [7:0]  w_rhs;
  logic [8:0]  w_sum;
  logic [8:0]  w_diff;
  logic [7:0]  w_res;
  logic [7:0]  w_nz;
  logic        w_c;
  logic        w_v;
  logic [3:0]  w_flags;
  logic [15:0] w_prod_next;
  logic        w_mul_hi;

  assign w_accept = req_valid & req_ready;

  // INC/DEC reuse the add/subtract paths with an implicit operand of 1.
  always_comb begin
    w_rhs     = (req_op == 4'hA || req_op == 4'hB) ? 8'h01 : req_b;
    w_sum     = {1'b0, req_a} + {1'b0, w_rhs};
    w_diff    = {1'b0, req_a} - {1'b0, w_rhs};
    w_is_mul  = (req_op == 4'hD) && (ENABLE_MUL != 0);
    w_illegal = (req_op >= 4'hE) || ((req_op == 4'hD) && (ENABLE_MUL == 0));
    w_res     = 8'h00;
    w_c       = 1'b0;
    w_v       = 1'b0;
    case (req_op)
      4'h0, 4'hA: begin
        w_res = w_sum[7:0];
        w_c   = w_sum[8];
        w_v   = (req_a[7] == w_rhs[7]) && (w_sum[7] != req_a[7]);
      end
      4'h1, 4'hB: begin
        w_res = w_diff[7:0];
        w_c   = w_diff[8];
        w_v   = (req_a[7] != w_rhs[7]) && (w_diff[7] != req_a[7]);
      end
      4'hC: begin
        w_res = req_a;
        w_c   = w_diff[8];
        w_v   = (req_a[7] != w_rhs[7]) && (w_diff[7] != req_a[7]);
      end
      4'h2: w_res = req_a & req_b;
      4'h3: w_res = req_a | req_b;
      4'h4: w_res = req_a ^ req_b;
      4'h5: w_res = ~req_a;
      4'h6: begin w_res = {req_a[6:0], 1'b0};     w_c = req_a[7]; end
      4'h7: begin w_res = {1'b0, req_a[7:1]};     w_c = req_a[0]; end
      4'h8: begin w_res = {req_a[6:0], req_a[7]}; w_c = req_a[7]; end
      4'h9: begin w_res = {req_a[0], req_a[7:1]}; w_c = req_a[0]; end
      default: ;
    endcase
    // CMP reports the operand but N/Z describe the subtraction.
    w_nz    = (req_op == 4'hC) ? w_diff[7:0] : w_res;
    w_flags = w_illegal ? 4'h0 : {w_v, w_c, w_nz[7], (w_nz == 8'h00)};
  end

  assign w_prod_next = r_prod + (r_mplier[0] ? r_mcand : 16'h0000);
  assign w_mul_hi    = (w_prod_next[15:8] != 8'h00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_alive  <= 1'b0;
      r_iter   <= 3'd0;
      r_mcand  <= 16'h0000;
      r_prod   <= 16'h0000;
      r_mplier <= 8'h00;
      r_result <= 8'h00;
      r_flags  <= 4'h0;
      r_err    <= 1'b0;
      r_tag    <= '0;
      r_count  <= '0;
    end else begin
      r_alive <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_tag <= req_tag;
            if (w_is_mul) begin
              r_mcand  <= {8'h00, req_a};
              r_mplier <= req_b;
              r_prod   <= 16'h0000;
              r_iter   <= 3'd0;
              r_state  <= S_EXEC;
            end else begin
              r_result <= w_res;
              r_flags  <= w_flags;
              r_err    <= w_illegal;
              r_state  <= S_RESP;
            end
          end
        end
        S_EXEC: begin
          r_prod   <= w_prod_next;
          r_mcand  <= {r_mcand[14:0], 1'b0};
          r_mplier <= {1'b0, r_mplier[7:1]};
          r_iter   <= r_iter + 3'd1;
          // Eighth iteration publishes straight into the response registers.
          if (r_iter == 3'd7) begin
            r_result <= w_prod_next[7:0];
            r_flags  <= {w_mul_hi, w_mul_hi, w_prod_next[7], (w_prod_next[7:0] == 8'h00)};
            r_err    <= 1'b0;
            r_state  <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_count <= r_count + CNT_W'(1);
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = r_alive && (r_state == S_IDLE);
  assign rsp_valid  = (r_state == S_RESP);
  assign busy       = (r_state != S_IDLE);
  assign rsp_result = r_result;
  assign rsp_flags  = r_flags;
  assign rsp_err    = r_err;
  assign rsp_tag    = r_tag;
  assign op_count   = r_count;

endmodule

// File: tb/tb_alu_cmd_responder.sv
// tb/tb_alu_cmd_responder.sv - scoreboard bench for alu_cmd_responder
// Directed vectors push expected responses; a negedge monitor pops and compares on each handshake.
module tb_alu_cmd_responder;

  typedef struct packed {
    logic [7:0] result;
    logic [3:0] flags;
    logic       err;
    logic [3:0] tag;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, rsp_valid, rsp_ready, rsp_err, busy;
  logic [3:0]  req_op, req_tag, rsp_flags, rsp_tag;
  logic [7:0]  req_a, req_b, rsp_result;
  logic [15:0] op_count;

  logic        req2_valid, req2_ready, rsp2_valid, rsp2_ready, rsp2_err, busy2;
  logic [3:0]  req2_op, req2_tag, rsp2_flags, rsp2_tag;
  logic [7:0]  req2_a, req2_b, rsp2_result;
  logic [1:0]  op_count2;

  rsp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   exp_count = 0;

  always #5 clk = ~clk;

  alu_cmd_responder #(.TAG_W(4), .ENABLE_MUL(1), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_flags(rsp_flags), .rsp_err(rsp_err), .rsp_tag(rsp_tag),
    .busy(busy), .op_count(op_count)
  );

  alu_cmd_responder #(.TAG_W(4), .ENABLE_MUL(0), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst),
    .req_valid(req2_valid), .req_ready(req2_ready), .req_op(req2_op),
    .req_a(req2_a), .req_b(req2_b), .req_tag(req2_tag),
    .rsp_valid(rsp2_valid), .rsp_ready(rsp2_ready), .rsp_result(rsp2_result),
    .rsp_flags(rsp2_flags), .rsp_err(rsp2_err), .rsp_tag(rsp2_tag),
    .busy(busy2), .op_count(op_count2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compares popped expectations and checks the response is frozen under backpressure.
  initial begin
    rsp_t cur, held, e;
    logic hold;
    hold = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      cur = {rsp_result, rsp_flags, rsp_err, rsp_tag};
      if (rst) begin
        hold      = 1'b0;
        exp_count = 0;
      end else begin
        if (hold && rsp_valid) chk("hold_stable", 32'(cur), 32'(held));
        if (rsp_valid && rsp_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_rsp: got %0h expected none", cur);
          end else begin
            e = exp_q.pop_front();
            chk("rsp_result", 32'(rsp_result), 32'(e.result));
            chk("rsp_flags", 32'(rsp_flags), 32'(e.flags));
            chk("rsp_err", 32'(rsp_err), 32'(e.err));
            chk("rsp_tag", 32'(rsp_tag), 32'(e.tag));
          end
          exp_count++;
        end
        hold = rsp_valid && !rsp_ready;
        held = cur;
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("req_ready_wait", 32'(req_ready), 32'd1);
  endtask

  task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [3:0] tag, input logic [7:0] er, input logic [3:0] ef,
                       input logic ee, input int elat);
    int   lat;
    int   bad;
    rsp_t e;
    wait_ready();
    chk("op_count", 32'(op_count), 32'(exp_count));
    req_op = op; req_a = a; req_b = b; req_tag = tag; req_valid = 1'b1;
    e = {er, ef, ee, tag};
    exp_q.push_back(e);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_op = 4'($urandom); req_a = 8'($urandom); req_b = 8'($urandom); req_tag = 4'($urandom);
    lat = 1;
    bad = 0;
    while (!rsp_valid && lat < 50) begin
      if (req_ready !== 1'b0 || busy !== 1'b1) bad++;
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'(elat));
    chk("exec_ready_busy", 32'(bad), 32'd0);
  endtask

  initial begin
    int   c0;
    logic saw;
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int   c0;
    logic saw;
    rst = 1'b1; rsp_ready = 1'b1;
    req_valid = 1'b0; req_op = 4'h0; req_a = 8'h00; req_b = 8'h00; req_tag = 4'h0;
    req2_valid = 1'b0; req2_op = 4'h0; req2_a = 8'h00; req2_b = 8'h00; req2_tag = 4'h0;
    rsp2_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_req_ready", 32'(req_ready), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_op_count", 32'(op_count), 32'd0);
    rst = 1'b0;
    #1;
    chk("ready_before_edge", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    chk("ready_after_edge", 32'(req_ready), 32'd1);

    issue(4'h0, 8'hFF, 8'h01, 4'h3, 8'h00, 4'b0101, 1'b0, 1);
    issue(4'h1, 8'h80, 8'h01, 4'h1, 8'h7F, 4'b1000, 1'b0, 1);
    issue(4'hC, 8'h05, 8'h07, 4'h2, 8'h05, 4'b0110, 1'b0, 1);
    issue(4'hD, 8'h10, 8'h11, 4'h4, 8'h10, 4'b1100, 1'b0, 9);
    issue(4'hD, 8'hFF, 8'hFF, 4'h5, 8'h01, 4'b1100, 1'b0, 9);
    issue(4'hD, 8'h03, 8'h05, 4'h6, 8'h0F, 4'b0000, 1'b0, 9);
    issue(4'h2, 8'hF0, 8'h3C, 4'h7, 8'h30, 4'b0000, 1'b0, 1);
    issue(4'h3, 8'h0F, 8'hF0, 4'h8, 8'hFF, 4'b0010, 1'b0, 1);
    issue(4'h4, 8'hAA, 8'hAA, 4'h9, 8'h00, 4'b0001, 1'b0, 1);
    issue(4'h5, 8'h00, 8'h12, 4'hB, 8'hFF, 4'b0010, 1'b0, 1);
    issue(4'h6, 8'h81, 8'h00, 4'hC, 8'h02, 4'b0100, 1'b0, 1);
    issue(4'h7, 8'h81, 8'h00, 4'hD, 8'h40, 4'b0100, 1'b0, 1);
    issue(4'h8, 8'h80, 8'h00, 4'hE, 8'h01, 4'b0100, 1'b0, 1);
    issue(4'hA, 8'h7F, 8'h00, 4'hF, 8'h80, 4'b1010, 1'b0, 1);
    issue(4'hB, 8'h00, 8'h00, 4'h0, 8'hFF, 4'b0110, 1'b0, 1);
    issue(4'h0, 8'h7F, 8'h01, 4'h1, 8'h80, 4'b1010, 1'b0, 1);
    issue(4'h1, 8'h05, 8'h05, 4'h2, 8'h00, 4'b0001, 1'b0, 1);
    issue(4'hE, 8'h12, 8'h34, 4'hA, 8'h00, 4'b0000, 1'b1, 1);
    issue(4'hF, 8'h56, 8'h78, 4'h5, 8'h00, 4'b0000, 1'b1, 1);

    // Backpressure: ROR held for five cycles.
    wait_ready();
    rsp_ready = 1'b0;
    issue(4'h9, 8'h01, 8'h00, 4'h6, 8'h80, 4'b0110, 1'b0, 1);
    repeat (5) begin
      @(posedge clk); #1;
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
    end
    c0 = int'(op_count);
    rsp_ready = 1'b1;
    chk("hs_cycle_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    chk("bp_op_count", 32'(op_count), 32'(c0 + 1));
    chk("bp_rsp_dropped", 32'(rsp_valid), 32'd0);
    chk("bp_ready_next", 32'(req_ready), 32'd1);

    // Reset four cycles into a multiply.
    wait_ready();
    req_op = 4'hD; req_a = 8'h10; req_b = 8'h11; req_tag = 4'h7; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("mid_busy_pre", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_outputs", 32'({rsp_result, rsp_flags, rsp_err, rsp_tag}), 32'd0);
    chk("rst_op_count", 32'(op_count), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    saw = 1'b0;
    repeat (15) begin
      @(posedge clk); #1;
      saw = saw | rsp_valid;
    end
    chk("no_rsp_after_reset", 32'(saw), 32'd0);
    issue(4'h0, 8'h02, 8'h03, 4'h3, 8'h05, 4'b0000, 1'b0, 1);
    @(posedge clk); #1;
    chk("post_reset_op_count", 32'(op_count), 32'd1);

    // MUL disabled instance: illegal with 1-cycle latency, 2-bit counter wraps.
    for (int i = 0; i < 5; i++) begin
      int n = 0;
      while (!req2_ready && n < 20) begin
        @(posedge clk); #1;
        n++;
      end
      req2_op = 4'hD; req2_a = 8'h10; req2_b = 8'h11; req2_tag = 4'(i); req2_valid = 1'b1;
      @(posedge clk); #1;
      req2_valid = 1'b0;
      chk("nomul_valid", 32'(rsp2_valid), 32'd1);
      chk("nomul_err", 32'(rsp2_err), 32'd1);
      chk("nomul_result", 32'({rsp2_result, rsp2_flags}), 32'd0);
      chk("nomul_tag", 32'(rsp2_tag), 32'(i));
      @(posedge clk); #1;
      chk("nomul_count_wrap", 32'(op_count2), 32'((i + 1) % 4));
    end

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
